fault_map_classifier: RTL and testbench

- Sits directly upstream of the eNVM fault store.
- Accumulates per-PE mismatch results from the SA/TD comparator into an SIZE×SIZE fault map over a full test run.
- Classifies faults as whole-row, whole-column or isolated PE.
- Streams the result row by row into the eNVM write interface (detection_en, counter, single_pe_detection, row/column bits), one row per cycle.

---
 rtl/strait_pkg.sv | 25 ++
 rtl/fault_line_counter.sv | 20 ++
 rtl/fault_map_classifier.sv | 195 +++++++++++++++++++
 tb/tb_fault_map_classifier.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strait_pkg.sv
// Shared types and helpers for the fault-map classifier: FSM encoding, default array size, popcount.
// Pure declarations, no logic of its own.
package strait_pkg;

  localparam int DEFAULT_SYSTOLIC_SIZE = 8;
  localparam int POPCOUNT_MAX_W        = 64;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    CLASSIFY,
    WRITE,
    DONE
  } fsm_state_t;

  function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fault_line_counter.sv
// Popcount of one row or column of the fault map, flagged when it reaches THRESHOLD.
// Latency: combinational. Backpressure: none.
// A THRESHOLD above WIDTH can never be reached, so that class is simply never flagged.
module fault_line_counter
  import strait_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_SYSTOLIC_SIZE,
  parameter int THRESHOLD = 4,
  parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             faulty
);

  logic [CNT_WIDTH-1:0] cnt;

  assign cnt    = CNT_WIDTH'(popcount(POPCOUNT_MAX_W'(vec)));
  assign faulty = (int'(cnt) >= THRESHOLD);

endmodule

// File: rtl/fault_map_classifier.sv
// Accumulates per-PE compare failures into a fault map, classifies row/column/isolated faults, streams one row per cycle to eNVM.
// Latency: test_done -> first detection_en = 2 cycles. Backpressure: none; the eNVM write port must accept every cycle.
// FAULT_COUNT_EN adds total_fault_count (set map bits, captured in CLASSIFY).
module fault_map_classifier
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int ROW_THRESHOLD = 4,
  parameter int COL_THRESHOLD = 4,
  parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     compare_valid,
  input  logic [ADDR_WIDTH-1:0]    compare_row,
  input  logic [SYSTOLIC_SIZE-1:0] compare_fail,
  input  logic                     test_done,
  output logic                     detection_en,
  output logic [ADDR_WIDTH-1:0]    counter,
  output logic [SYSTOLIC_SIZE-1:0] single_pe_detection,
  output logic                     row_fault_detection,
  output logic                     column_fault_detection,
  output logic                     busy,
  output logic                     done
`ifdef FAULT_COUNT_EN
  ,
  output logic [2*ADDR_WIDTH:0]    total_fault_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  typedef logic [SYSTOLIC_SIZE-1:0][SYSTOLIC_SIZE-1:0] map_t;

  fsm_state_t state_q, state_d;

  map_t                     map_q;    // [row][col]
  map_t                     map_t_c;  // transposed: [col][row]
  map_t                     iso_c, iso_q;
  logic [SYSTOLIC_SIZE-1:0] row_fault_c, row_fault_q;
  logic [SYSTOLIC_SIZE-1:0] col_fault_c, col_fault_q;
  logic [ADDR_WIDTH-1:0]    nxt_idx;

  assign nxt_idx = counter + ADDR_WIDTH'(1);

  always_comb begin
    map_t_c = '0;
    for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
      for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
        map_t_c[c][r] = map_q[r][c];
      end
    end
  end

  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_line
    fault_line_counter #(
      .WIDTH     (SYSTOLIC_SIZE),
      .THRESHOLD (ROW_THRESHOLD),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_row (
      .vec    (map_q[i]),
      .faulty (row_fault_c[i])
    );

    fault_line_counter #(
      .WIDTH     (SYSTOLIC_SIZE),
      .THRESHOLD (COL_THRESHOLD),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_col (
      .vec    (map_t_c[i]),
      .faulty (col_fault_c[i])
    );
  end

  // A PE is isolated only if neither its row nor its column is already reported whole.
  always_comb begin
    iso_c = '0;
    for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
      iso_c[r] = map_q[r] & ~{SYSTOLIC_SIZE{row_fault_c[r]}} & ~col_fault_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // start from any state restarts accumulation.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        ACCUM:    if (test_done) state_d = CLASSIFY;
        CLASSIFY: state_d = WRITE;
        WRITE:    if (counter == LAST_IDX) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= '0;
    end else if (start) begin
      map_q <= '0;
    end else if (state_q == ACCUM && compare_valid) begin
      map_q[compare_row] <= map_q[compare_row] | compare_fail;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_fault_q <= '0;
      col_fault_q <= '0;
      iso_q       <= '0;
    end else if (state_q == CLASSIFY) begin
      row_fault_q <= row_fault_c;
      col_fault_q <= col_fault_c;
      iso_q       <= iso_c;
    end
  end

  // Row 0 is loaded straight from the classifier so WRITE starts the cycle after CLASSIFY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detection_en           <= 1'b0;
      counter                <= '0;
      single_pe_detection    <= '0;
      row_fault_detection    <= 1'b0;
      column_fault_detection <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_d == ACCUM) || (state_d == CLASSIFY) || (state_d == WRITE);
      if (start) begin
        detection_en           <= 1'b0;
        counter                <= '0;
        single_pe_detection    <= '0;
        row_fault_detection    <= 1'b0;
        column_fault_detection <= 1'b0;
      end else if (state_q == CLASSIFY) begin
        detection_en           <= 1'b1;
        counter                <= '0;
        single_pe_detection    <= iso_c[0];
        row_fault_detection    <= row_fault_c[0];
        column_fault_detection <= col_fault_c[0];
      end else if (state_q == WRITE) begin
        if (counter == LAST_IDX) begin
          detection_en           <= 1'b0;
          counter                <= '0;
          single_pe_detection    <= '0;
          row_fault_detection    <= 1'b0;
          column_fault_detection <= 1'b0;
          done                   <= 1'b1;
        end else begin
          counter                <= nxt_idx;
          single_pe_detection    <= iso_q[nxt_idx];
          row_fault_detection    <= row_fault_q[nxt_idx];
          column_fault_detection <= col_fault_q[nxt_idx];
        end
      end
    end
  end

`ifdef FAULT_COUNT_EN
  localparam int TOT_W = 2 * ADDR_WIDTH + 1;

  int unsigned total_sum;

  always_comb begin
    total_sum = 0;
    for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
      total_sum = total_sum + popcount(POPCOUNT_MAX_W'(map_q[r]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_fault_count <= '0;
    end else if (start) begin
      total_fault_count <= '0;
    end else if (state_q == CLASSIFY) begin
      total_fault_count <= TOT_W'(total_sum);
    end
  end
`endif

endmodule

// File: tb/tb_fault_map_classifier.sv
// Randomized and directed bench for fault_map_classifier against a map-level reference model.
module tb_fault_map_classifier;

  localparam int N      = 8;
  localparam int AW     = 3;
  localparam int ROW_TH = 4;
  localparam int COL_TH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          compare_valid = 1'b0;
  logic [AW-1:0] compare_row = '0;
  logic [N-1:0]  compare_fail = '0;
  logic          test_done = 1'b0;
  logic          detection_en;
  logic [AW-1:0] counter;
  logic [N-1:0]  single_pe_detection;
  logic          row_fault_detection;
  logic          column_fault_detection;
  logic          busy;
  logic          done;
`ifdef FAULT_COUNT_EN
  logic [2*AW:0] total_fault_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0]  ref_map [N];
  logic [AW-1:0] q_row [$];
  logic [N-1:0]  q_fail [$];

  always #5 clk = ~clk;

  fault_map_classifier #(
    .SYSTOLIC_SIZE (N),
    .ADDR_WIDTH    (AW),
    .ROW_THRESHOLD (ROW_TH),
    .COL_THRESHOLD (COL_TH),
    .CNT_WIDTH     (AW + 1)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .compare_valid          (compare_valid),
    .compare_row            (compare_row),
    .compare_fail           (compare_fail),
    .test_done              (test_done),
    .detection_en           (detection_en),
    .counter                (counter),
    .single_pe_detection    (single_pe_detection),
    .row_fault_detection    (row_fault_detection),
    .column_fault_detection (column_fault_detection),
    .busy                   (busy),
    .done                   (done)
`ifdef FAULT_COUNT_EN
    ,
    .total_fault_count      (total_fault_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int r = 0; r < N; r++) ref_map[r] = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_den"},  32'(detection_en), 0);
    check({tag, "_cnt"},  32'(counter), 0);
    check({tag, "_iso"},  32'(single_pe_detection), 0);
    check({tag, "_row"},  32'(row_fault_detection), 0);
    check({tag, "_col"},  32'(column_fault_detection), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
`ifdef FAULT_COUNT_EN
    check({tag, "_total"}, 32'(total_fault_count), 0);
`endif
  endtask

  task automatic push(input logic [AW-1:0] r, input logic [N-1:0] f);
    q_row.push_back(r);
    q_fail.push_back(f);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_ref();
    check("start_busy", 32'(busy), 1);
    check("start_den", 32'(detection_en), 0);
  endtask

  // Applies queued results; optionally the last one shares its cycle with test_done.
  task automatic feed(input bit same_cycle);
    int n = q_row.size();
    for (int i = 0; i < n; i++) begin
      compare_valid = 1'b1;
      compare_row   = q_row[i];
      compare_fail  = q_fail[i];
      ref_map[q_row[i]] = ref_map[q_row[i]] | q_fail[i];
      if (same_cycle && i == n - 1) test_done = 1'b1;
      tick();
    end
    compare_valid = 1'b0;
    compare_fail  = '0;
    if (!(same_cycle && n > 0)) begin
      test_done = 1'b1;
      tick();
    end
    test_done = 1'b0;
    check("lat1_den", 32'(detection_en), 0);
    check("lat1_busy", 32'(busy), 1);
    tick();
    q_row.delete();
    q_fail.delete();
  endtask

  // abort_kind 0: start pulse at abort_at; 1: async reset at abort_at.
  task automatic check_write(input int abort_at, input int abort_kind);
    int           rc [N];
    int           cc [N];
    bit           rf [N];
    bit           cf [N];
    int           total;
    logic [N-1:0] exp_iso;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rc[i] = 0;
      cc[i] = 0;
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (ref_map[r][c]) begin
          rc[r]++;
          cc[c]++;
          total++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      rf[i] = (rc[i] >= ROW_TH);
      cf[i] = (cc[i] >= COL_TH);
    end
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < N; c++) exp_iso[c] = ref_map[k][c] && !rf[k] && !cf[c];
      check($sformatf("wr%0d_den", k), 32'(detection_en), 1);
      check($sformatf("wr%0d_cnt", k), 32'(counter), 32'(k));
      check($sformatf("wr%0d_iso", k), 32'(single_pe_detection), 32'(exp_iso));
      check($sformatf("wr%0d_row", k), 32'(row_fault_detection), 32'(rf[k]));
      check($sformatf("wr%0d_col", k), 32'(column_fault_detection), 32'(cf[k]));
      check($sformatf("wr%0d_done", k), 32'(done), 0);
`ifdef FAULT_COUNT_EN
      if (k == 0) check("wr_total", 32'(total_fault_count), 32'(total));
`endif
      if (k == abort_at) begin
        if (abort_kind == 0) begin
          start = 1'b1;
          tick();
          start = 1'b0;
          clear_ref();
          check("abort_den", 32'(detection_en), 0);
          check("abort_done", 32'(done), 0);
          check("abort_busy", 32'(busy), 1);
`ifdef FAULT_COUNT_EN
          check("abort_total", 32'(total_fault_count), 0);
`endif
        end else begin
          #2 rst_n = 1'b0;
          #1 check_zero("arst");
          #2 rst_n = 1'b1;
          tick();
          check("arst_idle_busy", 32'(busy), 0);
          check("arst_idle_den", 32'(detection_en), 0);
        end
        return;
      end
      tick();
    end
    check("end_done", 32'(done), 1);
    check("end_den", 32'(detection_en), 0);
    check("end_busy", 32'(busy), 0);
    tick();
    check("end_done_pulse", 32'(done), 0);
  endtask

  task automatic idle_ignores();
    compare_valid = 1'b1;
    compare_row   = 3'd3;
    compare_fail  = '1;
    test_done     = 1'b1;
    tick();
    compare_valid = 1'b0;
    compare_fail  = '0;
    test_done     = 1'b0;
    tick();
    tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_den", 32'(detection_en), 0);
    check("idle_done", 32'(done), 0);
  endtask

  int           nv;
  int           mode;
  logic [N-1:0] f;

  initial begin
    clear_ref();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check_zero("post_reset");
    idle_ignores();

    pulse_start();
    push(3'd3, 8'h04);
    feed(1'b0);
    check_write(-1, 0);

    pulse_start();
    push(3'd5, 8'hF0);
    feed(1'b0);
    check_write(-1, 0);

    pulse_start();
    push(3'd0, 8'h02);
    push(3'd1, 8'h02);
    push(3'd2, 8'h02);
    push(3'd6, 8'h02);
    push(3'd6, 8'h80);
    feed(1'b0);
    check_write(-1, 0);

    pulse_start();
    push(3'd2, 8'h01);
    push(3'd2, 8'h10);
    feed(1'b1);
    check_write(-1, 0);

    pulse_start();
    push(3'd1, 8'hFF);
    push(3'd4, 8'h08);
    feed(1'b0);
    check_write(4, 0);
    feed(1'b0);
    check_write(-1, 0);

    pulse_start();
    push(3'd7, 8'h3C);
    push(3'd0, 8'h01);
    feed(1'b0);
    check_write(3, 1);
    idle_ignores();

    for (int t = 0; t < 30; t++) begin
      nv   = $urandom_range(1, 14);
      mode = $urandom_range(0, 3);
      pulse_start();
      for (int i = 0; i < nv; i++) begin
        case (mode)
          0:       f = N'($urandom & $urandom & $urandom);
          1:       f = N'($urandom & $urandom);
          2:       f = N'($urandom);
          default: f = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'(8'h01 << $urandom_range(0, N - 1));
        endcase
        push(AW'($urandom_range(0, N - 1)), f);
      end
      feed(1'($urandom_range(0, 1)));
      check_write(-1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
